keypad_scan_debounce: RTL and testbench
=======================================

KEYPAD_SCAN_DEBOUNCE -- requirements
Module: keypad_scan_debounce

Interface
REQ-001 Parameter ROWS, default 4: number of keypad rows driven.
REQ-002 Parameter COLS, default 4: number of keypad columns sensed.
REQ-003 Parameter SCAN_DIV, default 250000: clocks each row stays driven; legal range >= 4.
REQ-004 Parameter DEBOUNCE, default 4: consecutive identical frame results needed to change key state; legal range >= 1.
REQ-005 Parameter CODE_W, default 4: key code width, >= ceil(log2(ROWS*COLS)).
REQ-006 clk  input  1  system clock; all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 keypadCol  input  COLS  column sense lines, active low, asynchronous to clk.
REQ-009 keypadRow  output  ROWS  row drive, exactly one bit low at all times.
REQ-010 key_code  output  CODE_W  linear index of the last accepted key: row_index*COLS + col_index.
REQ-011 key_valid  output  1  one-cycle pulse when a debounced press is accepted.
REQ-012 key_held  output  1  level, high while the accepted key stays pressed.
REQ-013 key_release  output  1  one-cycle pulse when a debounced release is accepted.
REQ-014 multi_key  output  1  level, high while the most recent frame saw more than one pressed key.

Function
REQ-015 keypadCol SHALL pass through a 2-flop synchroniser before use.
REQ-016 Dwell counter SHALL count 0..SCAN_DIV-1 and wrap; at count SCAN_DIV-1 the synchronised columns are sampled and the row index advances in the same cycle.
REQ-017 Row index SHALL step 0,1,..,ROWS-1,0; keypadRow = all ones with bit[row_index] low.
REQ-018 Per sample: zero low columns -> no hit; one low column c -> hit with code row_index*COLS+c; more than one -> multi.
REQ-019 Hits SHALL accumulate across one frame (ROWS samples); frame result = NONE (0 hits), SINGLE(code) (exactly 1 hit), MULTI (>1 hit or any multi sample).
REQ-020 Frame result SHALL be evaluated on the sample of row ROWS-1; accumulator clears in the same cycle.
REQ-021 multi_key SHALL update at each frame end: 1 if result MULTI, else 0.
REQ-022 Debounce FSM states: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND; debounce counter counts matching frames.
REQ-023 RELEASED: SINGLE(k) -> PRESS_PEND, candidate=k, count=1 (if DEBOUNCE=1, go directly to PRESSED per REQ-025).
REQ-024 PRESS_PEND: SINGLE(candidate) -> count+1; SINGLE(other) -> restart with new candidate, count=1; NONE -> RELEASED.
REQ-025 Count reaching DEBOUNCE in PRESS_PEND -> PRESSED; key_code<=candidate and key_valid pulses the cycle after that frame end.
REQ-026 PRESSED: NONE or SINGLE(other) -> RELEASE_PEND, count=1; SINGLE(key_code) -> stay.
REQ-027 RELEASE_PEND: SINGLE(key_code) -> PRESSED; NONE/SINGLE(other) -> count+1; count reaching DEBOUNCE -> RELEASED with key_release pulse.
REQ-028 MULTI frames SHALL leave FSM state and debounce count unchanged in every state.
REQ-029 key_held SHALL be 1 in PRESSED and RELEASE_PEND, else 0.
REQ-030 key_code SHALL change only on press acceptance; it holds after release.
REQ-031 key_valid and key_release SHALL never assert in the same cycle; each is exactly one clock wide.

Reset
REQ-032 While reset=1: keypadRow={ROWS{1}} with bit0 low, key_code=0, key_valid=0, key_held=0, key_release=0, multi_key=0, FSM=RELEASED, all counters, accumulator and synchroniser cleared.
REQ-033 Reset asserted mid-scan or mid-debounce SHALL abort immediately with no pulse emitted; scanning restarts at row 0 on the first edge after deassertion.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3, CODE_W=4; frame = 16 clocks)
REQ-034 Reset, keypadCol=4'b1111 -> keypadRow=4'b1110, all outputs 0; after deassert keypadRow 1101 after 4 clocks, 1011, 0111, back to 1110 after 16.
REQ-035 Key row2/col1 held (keypadCol=4'b1101 while keypadRow=4'b1011) -> single key_valid pulse after 3rd full frame, key_code=9, key_held=1; no further pulses while held.
REQ-036 Key pressed for 2 frames then released -> no key_valid, key_held stays 0.
REQ-037 After REQ-035, release for 3 frames -> one key_release pulse, key_held=0, key_code stays 9; a 1-frame release gap does not release.
REQ-038 Keys 0 and 5 held together -> multi_key=1 at frame end, no key_valid, FSM unchanged; removing key 5 -> after 3 frames key_valid, key_code=0.
REQ-039 Reset pulsed during PRESS_PEND (2 frames into a press) -> no key_valid, outputs return to reset values, press re-debounced from scratch.

Source files
------------

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: row-scanning matrix keypad reader with frame-based debounce.
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   keypadCol    active-low column sense lines (asynchronous)
//   keypadRow    active-low row drive, one bit low at a time
//   key_code     row*COLS+col of the last accepted key
//   key_valid    one-cycle pulse on accepted press
//   key_held     high while the accepted key stays pressed
//   key_release  one-cycle pulse on accepted release
//   multi_key    high while the last frame saw more than one key
module keypad_scan_debounce #(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int SCAN_DIV = 250000,
   parameter int DEBOUNCE = 4,
   parameter int CODE_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [COLS-1:0]   keypadCol,
   output logic [ROWS-1:0]   keypadRow,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_held,
   output logic              key_release,
   output logic              multi_key
);
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int ROW_W = ROWS > 1 ? $clog2(ROWS) : 1;
   localparam int DB_W  = $clog2(DEBOUNCE + 1);
   typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} state_t;
   state_t              state;
   logic [COLS-1:0]     col_meta, col_sync, low;
   logic [DIV_W-1:0]    div_cnt;
   logic [ROW_W-1:0]    row_idx;
   logic [1:0]          acc_hits, frame_hits;
   logic [CODE_W-1:0]   acc_code, col_idx, samp_code, fr_code, cand;
   logic                acc_multi, sample, frame_end, samp_hit, samp_multi;
   logic                fr_multi, fr_none, fr_single;
   logic [DB_W-1:0]     db_cnt, db_next;
   always_comb begin
      low        = ~col_sync;
      sample     = div_cnt == DIV_W'(SCAN_DIV - 1);
      frame_end  = sample && row_idx == ROW_W'(ROWS - 1);
      samp_hit   = low != '0 && (low & (low - 1'b1)) == '0;
      samp_multi = low != '0 && !samp_hit;
      col_idx    = '0;
      for (int c = 0; c < COLS; c++)
         if (low[c]) col_idx = CODE_W'(c);
      samp_code  = CODE_W'(int'(row_idx) * COLS) + col_idx;
      // acc_hits saturates at 2, so the 2-bit sum cannot overflow past "more than one"
      frame_hits = acc_hits + {1'b0, samp_hit};
      fr_multi   = acc_multi || samp_multi || frame_hits > 2'd1;
      fr_none    = !fr_multi && frame_hits == 2'd0;
      fr_single  = !fr_multi && frame_hits == 2'd1;
      fr_code    = samp_hit ? samp_code : acc_code;
      db_next    = db_cnt + 1'b1;
      keypadRow  = ~(ROWS'(1) << row_idx);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_meta  <= '1;
         col_sync  <= '1;
         div_cnt   <= '0;
         row_idx   <= '0;
         acc_hits  <= '0;
         acc_code  <= '0;
         acc_multi <= 1'b0;
         multi_key <= 1'b0;
      end else begin
         col_meta <= keypadCol;
         col_sync <= col_meta;
         div_cnt  <= sample ? '0 : div_cnt + 1'b1;
         if (sample) begin
            row_idx <= frame_end ? '0 : row_idx + 1'b1;
            if (frame_end) begin
               acc_hits  <= '0;
               acc_multi <= 1'b0;
               multi_key <= fr_multi;
            end else begin
               acc_hits  <= frame_hits > 2'd2 ? 2'd2 : frame_hits;
               acc_multi <= acc_multi | samp_multi;
               if (samp_hit) acc_code <= samp_code;
            end
         end
      end
   end
   // Debounce FSM advances only on non-MULTI frame results
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RELEASED;
         cand        <= '0;
         db_cnt      <= '0;
         key_code    <= '0;
         key_valid   <= 1'b0;
         key_release <= 1'b0;
         key_held    <= 1'b0;
      end else begin
         key_valid   <= 1'b0;
         key_release <= 1'b0;
         if (frame_end && !fr_multi) begin
            case (state)
               RELEASED:
                  if (fr_single) begin
                     cand <= fr_code;
                     if (DEBOUNCE == 1) begin
                        state     <= PRESSED;
                        key_code  <= fr_code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                     end else begin
                        state  <= PRESS_PEND;
                        db_cnt <= DB_W'(1);
                     end
                  end
               PRESS_PEND:
                  if (fr_none) begin
                     state  <= RELEASED;
                     db_cnt <= '0;
                  end else if (fr_code != cand) begin
                     cand   <= fr_code;
                     db_cnt <= DB_W'(1);
                  end else if (db_next == DB_W'(DEBOUNCE)) begin
                     state     <= PRESSED;
                     key_code  <= cand;
                     key_valid <= 1'b1;
                     key_held  <= 1'b1;
                     db_cnt    <= '0;
                  end else begin
                     db_cnt <= db_next;
                  end
               PRESSED:
                  if (fr_none || fr_code != key_code) begin
                     if (DEBOUNCE == 1) begin
                        state       <= RELEASED;
                        key_release <= 1'b1;
                        key_held    <= 1'b0;
                     end else begin
                        state  <= RELEASE_PEND;
                        db_cnt <= DB_W'(1);
                     end
                  end
               RELEASE_PEND:
                  if (fr_single && fr_code == key_code) begin
                     state  <= PRESSED;
                     db_cnt <= '0;
                  end else if (db_next == DB_W'(DEBOUNCE)) begin
                     state       <= RELEASED;
                     key_release <= 1'b1;
                     key_held    <= 1'b0;
                     db_cnt      <= '0;
                  end else begin
                     db_cnt <= db_next;
                  end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb_keypad_scan_debounce: directed bench with a keypad matrix model and an event scoreboard.
module tb_keypad_scan_debounce;
   typedef struct {logic rel; logic [3:0] code;} ev_t;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  keypadCol, keypadRow, key_code;
   logic        key_valid, key_held, key_release, multi_key;
   logic [15:0] pressed;
   ev_t         exp_q[$];
   ev_t         mon_e;
   int          vectors = 0;
   int          errors = 0;
   keypad_scan_debounce #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .CODE_W(4)) dut (
      .clk(clk), .reset(reset), .keypadCol(keypadCol), .keypadRow(keypadRow),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
      .key_release(key_release), .multi_key(multi_key)
   );
   always #5 clk = ~clk;
   // A pressed key shorts its column low while its row is driven low
   always_comb begin
      keypadCol = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!keypadRow[r] && pressed[r*4+c]) keypadCol[c] = 1'b0;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask
   always @(negedge clk)
      if (key_valid || key_release) begin
         chk("valid_release_exclusive", {31'd0, key_valid & key_release}, 0);
         if (exp_q.size() == 0) chk("spurious_event", {31'd0, key_valid | key_release}, 0);
         else begin
            mon_e = exp_q.pop_front();
            chk("event_kind", {31'd0, key_release}, {31'd0, mon_e.rel});
            chk("event_code", {28'd0, key_code}, {28'd0, mon_e.code});
         end
      end
   initial begin
      reset = 1'b1;
      pressed = '0;
      step(2);
      chk("rst_row", keypadRow, 4'b1110);
      chk("rst_code", key_code, 0);
      chk("rst_valid", key_valid, 0);
      chk("rst_held", key_held, 0);
      chk("rst_release", key_release, 0);
      chk("rst_multi", multi_key, 0);
      reset = 1'b0;
      step(4);  chk("row1", keypadRow, 4'b1101);
      step(4);  chk("row2", keypadRow, 4'b1011);
      step(4);  chk("row3", keypadRow, 4'b0111);
      step(4);  chk("row0_wrap", keypadRow, 4'b1110);
      chk("idle_multi", multi_key, 0);
      pressed = 16'h1 << 9;
      exp_q.push_back('{1'b0, 4'd9});
      step(32); chk("pend_held", key_held, 0);
      chk("pend_valid", key_valid, 0);
      step(16); chk("press_valid", key_valid, 1);
      chk("press_code", key_code, 9);
      chk("press_held", key_held, 1);
      step(1);  chk("valid_width", key_valid, 0);
      step(31); chk("still_held", key_held, 1);
      pressed = '0;
      step(16); chk("gap_held", key_held, 1);
      pressed = 16'h1 << 9;
      step(16); chk("gap_recover_held", key_held, 1);
      chk("gap_no_release", key_release, 0);
      pressed = '0;
      exp_q.push_back('{1'b1, 4'd9});
      step(32); chk("rel_pend_held", key_held, 1);
      step(16); chk("release_pulse", key_release, 1);
      chk("release_held", key_held, 0);
      chk("release_code", key_code, 9);
      step(1);  chk("release_width", key_release, 0);
      step(15);
      pressed = 16'h1 << 6;
      step(32);
      pressed = '0;
      step(16); chk("short_held", key_held, 0);
      chk("short_valid", key_valid, 0);
      chk("short_code", key_code, 9);
      pressed = 16'h0021;
      step(16); chk("multi_set", multi_key, 1);
      chk("multi_held", key_held, 0);
      step(16); chk("multi_stay", multi_key, 1);
      pressed = 16'h0001;
      exp_q.push_back('{1'b0, 4'd0});
      step(16); chk("multi_clear", multi_key, 0);
      step(32); chk("key0_valid", key_valid, 1);
      chk("key0_code", key_code, 0);
      chk("key0_held", key_held, 1);
      pressed = 16'h0021;
      step(16); chk("multi_in_pressed", multi_key, 1);
      chk("multi_keeps_held", key_held, 1);
      pressed = '0;
      exp_q.push_back('{1'b1, 4'd0});
      step(32); chk("multi_no_early_rel", key_release, 0);
      chk("multi_rel_pend_held", key_held, 1);
      step(16); chk("key0_release", key_release, 1);
      chk("key0_rel_held", key_held, 0);
      pressed = 16'h1 << 9;
      step(32); chk("pre_reset_held", key_held, 0);
      reset = 1'b1;
      step(1);  chk("mid_rst_row", keypadRow, 4'b1110);
      chk("mid_rst_code", key_code, 0);
      chk("mid_rst_held", key_held, 0);
      chk("mid_rst_valid", key_valid, 0);
      chk("mid_rst_multi", multi_key, 0);
      step(3);
      reset = 1'b0;
      exp_q.push_back('{1'b0, 4'd9});
      step(32); chk("redeb_valid_early", key_valid, 0);
      chk("redeb_held_early", key_held, 0);
      step(16); chk("redeb_valid", key_valid, 1);
      chk("redeb_code", key_code, 9);
      chk("redeb_held", key_held, 1);
      step(16);
      chk("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
